// File: rtl/if_fetch_queue_pkg.sv
// if_pkg: shared types and defaults for the instruction-fetch front end.
package if_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned INSN_W_DEF  = 32;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [INSN_W_DEF-1:0] insn_t;

    localparam addr_t       RESET_PC_DEF = '0;
    localparam int unsigned PC_STEP_DEF  = 4;

    typedef struct packed {
        addr_t pc;
        insn_t insn;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_buf.sv
// fetch_buf: first-word-fall-through FIFO of fetch entries with a single-cycle flush.
module fetch_buf
    import if_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output entry_t                   head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC owner issuing pipelined imem requests and buffering
// returned instructions for decode; redirects flush and discard stale responses.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W    = ADDR_W_DEF,
    parameter int unsigned       INSN_W    = INSN_W_DEF,
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned       PC_STEP   = PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INSN_W-1:0] out_insn,
    output logic              busy
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } entry_t;

    localparam int unsigned       OW   = $clog2(MAX_OUTST + 1);
    localparam int unsigned       CW   = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     drop_cnt;
    logic [CW-1:0]     occ;
    logic              buf_empty;
    logic              buf_full;
    logic              fire;
    logic              push;
    entry_t            push_data;
    entry_t            head;

    logic [ADDR_W-1:0] fetch_pc_next;
    logic [ADDR_W-1:0] resp_pc_next;
    logic [OW-1:0]     outstanding_next;
    logic [OW-1:0]     drop_cnt_next;

    // Stale requests still hold credit, so every live response has a free slot.
    assign imem_req_valid = rst
                         && (32'(occ) + 32'(outstanding) < DEPTH)
                         && (32'(outstanding) < MAX_OUTST);
    assign imem_req_addr  = fetch_pc;
    assign fire           = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
    assign push_data      = '{pc: resp_pc, insn: imem_rsp_data};

    assign out_valid = !buf_empty;
    assign out_pc    = head.pc;
    assign out_insn  = head.insn;
    assign busy      = outstanding != '0 || !buf_empty;

    always_comb begin
        outstanding_next = outstanding + OW'(fire) - OW'(imem_rsp_valid);
        drop_cnt_next    = redirect_valid ? outstanding_next
                         : (imem_rsp_valid && drop_cnt != '0) ? drop_cnt - 1'b1
                         : drop_cnt;
        fetch_pc_next    = redirect_valid ? redirect_addr
                         : fire ? fetch_pc + STEP
                         : fetch_pc;
        resp_pc_next     = redirect_valid ? redirect_addr
                         : push ? resp_pc + STEP
                         : resp_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            fetch_pc    <= fetch_pc_next;
            resp_pc     <= resp_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

    fetch_buf #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .flush     (redirect_valid),
        .head      (head),
        .empty     (buf_empty),
        .full      (buf_full),
        .count     (occ)
    );

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> outstanding != '0);
    a_drop_le_outst: assert property (@(posedge clk) disable iff (!rst)
        drop_cnt <= outstanding);
    a_credit: assert property (@(posedge clk) disable iff (!rst)
        32'(occ) + 32'(outstanding) <= DEPTH);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (buf_full && push) |-> out_ready);

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized scoreboard bench with an epoch-tagged memory model.
module tb_if_fetch_queue;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_insn;
    logic        busy;

    always #5 clk = ~clk;

    if_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_insn       (out_insn),
        .busy           (busy)
    );

    typedef struct {
        logic [31:0] daddr;
        logic [31:0] maddr;
        int          tag;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    req_t        pend[$];
    ent_t        sb[$];
    int          epoch = 0;
    logic [31:0] model_pc = RESET_PC;
    int          errors = 0;
    int          checks = 0;
    int          p_ready = 100, p_rsp = 100, p_out = 100, p_redir = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs mid-cycle against the scoreboard and model.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            chk("busy", 64'(busy), 64'(sb.size() != 0 || pend.size() != 0));
            chk("req_valid", 64'(imem_req_valid),
                64'((sb.size() + pend.size() < DEPTH) && (pend.size() < MAX_OUTST)));
            if (imem_req_valid) chk("req_addr", 64'(imem_req_addr), 64'(model_pc));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got pc %0h expected no output", out_pc);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("out_pc", 64'(out_pc), 64'(e.pc));
                    chk("out_insn", 64'(out_insn), 64'(e.insn));
                end
            end
        end
    end

    // Tracker: captures the cycle's handshakes and applies them to the model at the edge.
    initial forever begin
        logic        c_rst, c_fire, c_rsp, c_red;
        logic [31:0] c_addr, c_raddr;
        req_t        r;
        @(negedge clk);
        c_rst   = rst;
        c_fire  = imem_req_valid && imem_req_ready;
        c_addr  = imem_req_addr;
        c_rsp   = imem_rsp_valid;
        c_red   = redirect_valid;
        c_raddr = redirect_addr;
        @(posedge clk);
        if (!c_rst) begin
            pend.delete();
            sb.delete();
            model_pc = RESET_PC;
            epoch++;
        end else begin
            if (c_rsp && pend.size() > 0) begin
                r = pend.pop_front();
                if (r.tag == epoch && !c_red) begin
                    ent_t e;
                    e.pc   = r.maddr;
                    e.insn = mem_word(r.maddr);
                    sb.push_back(e);
                end
            end
            if (c_fire) begin
                r.daddr = c_addr;
                r.maddr = model_pc;
                r.tag   = epoch;
                pend.push_back(r);
            end
            if (c_red) begin
                sb.delete();
                epoch++;
                model_pc = c_raddr;
            end else if (c_fire) begin
                model_pc = model_pc + 32'd4;
            end
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
        imem_req_ready = ($urandom % 100) < p_ready;
        out_ready      = ($urandom % 100) < p_out;
        redirect_valid = ($urandom % 100) < p_redir;
        redirect_addr  = $urandom & 32'hFFFF_FFFC;
        if (pend.size() > 0 && ($urandom % 100) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].daddr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic redir(logic [31:0] a);
        drive();
        redirect_valid = 1'b1;
        redirect_addr  = a;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) drive();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_req_valid", 64'(imem_req_valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #3 rst = 1'b1;
        run(20);
        p_out = 0;
        run(12);
        p_out = 100;
        run(10);
        p_rsp = 0;
        run(3);
        redir(32'h100);
        p_rsp = 100;
        run(10);
        run(5);
        redir(32'h100);
        run(8);
        redir(32'h200);
        redir(32'h300);
        run(10);
        redir(32'hFFFF_FFF8);
        run(10);
        p_ready = 70; p_rsp = 60; p_out = 60; p_redir = 5;
        run(1500);
        p_ready = 100; p_rsp = 100; p_out = 0; p_redir = 0;
        run(10);
        @(posedge clk);
        #3;
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'(0));
        chk("async_rst_req_valid", 64'(imem_req_valid), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        p_out = 100;
        run(20);
        p_ready = 70; p_rsp = 50; p_out = 50; p_redir = 10;
        run(800);
        p_ready = 0; p_rsp = 100; p_out = 100; p_redir = 0;
        run(15);
        chk("drained_busy", 64'(busy), 64'(0));
        chk("drained_out_valid", 64'(out_valid), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch front end: owns the fetch PC, issues pipelined requests to instruction memory with a valid/ready request channel and an in-order response channel, and buffers returned instructions with their PCs in a DEPTH-entry queue.
- Presents instructions to decode with a valid/ready handshake.
- A redirect (jump/branch) flushes the queue, discards stale in-flight responses and restarts fetch at the new address.

Parameters:
- ADDR_W, 32, fetch address width
- INSN_W, 32, instruction width
- DEPTH, 4, queue entries (power of two, >=2)
- MAX_OUTST, 2, max in-flight memory requests (>=1)
- RESET_PC, 0, fetch address after reset
- PC_STEP, 4, sequential PC increment

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- redirect_valid  in  1  jump taken this cycle
- redirect_addr  in  ADDR_W  new fetch address
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  request address (= fetch_pc)
- imem_rsp_valid  in  1  response valid (in order, no backpressure)
- imem_rsp_data  in  INSN_W  response instruction
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_pc  out  ADDR_W  head PC
- out_insn  out  INSN_W  head instruction
- busy  out  1  outstanding != 0 or queue non-empty

Behaviour:
- Reset (rst low, async):
  - fetch_pc = resp_pc = RESET_PC; queue empty; outstanding = 0; drop_cnt = 0.
  - imem_req_valid = 0, out_valid = 0, busy = 0.
- Credit rule:
  - imem_req_valid = (occ + outstanding < DEPTH) && (outstanding < MAX_OUTST).
  - outstanding includes stale requests, so a queue slot is guaranteed for every live response and the queue never overflows.
- Request issue:
  - A request fires when imem_req_valid && imem_req_ready.
  - On fire: fetch_pc += PC_STEP (modulo 2^ADDR_W, wraps silently) and outstanding++.
- Response handling:
  - Every imem_rsp_valid decrements outstanding.
  - If drop_cnt > 0: response discarded, drop_cnt--.
  - Else: {resp_pc, imem_rsp_data} is pushed and resp_pc += PC_STEP.
- Output:
  - First-word-fall-through: out_valid = !empty, with out_pc/out_insn driven from the head.
  - Pop on out_valid && out_ready.
  - Response-to-out_valid latency: 1 cycle. A response pushed in cycle N is visible at out_* in N+1.
- Same-cycle push, pop and issue: occupancy and outstanding update by net delta; a full queue may pop and push in the same cycle.
- Redirect (highest priority):
  - Queue flushed; a pop in the same cycle still counts as a transfer to decode, but that is decode's responsibility.
  - fetch_pc = resp_pc = redirect_addr.
  - drop_cnt = outstanding_next, counting requests fired this cycle but excluding a response consumed this cycle.
  - Request fire in the redirect cycle uses the old fetch_pc and is counted as stale.
  - Back-to-back redirects: the latest wins; drop_cnt is recomputed each time.
- Invariants:
  - drop_cnt <= outstanding <= MAX_OUTST.
  - occ + outstanding <= DEPTH.
  - A response with outstanding == 0 is a protocol error; assertion only.
- Reset mid-operation clears all state immediately. Responses arriving after reset release are not expected; the memory side is reset together with this block.

Decomposition:
- Package if_pkg:
  - addr_t, insn_t typedefs
  - RESET_PC and PC_STEP defaults
  - fetch_entry_t struct {pc, insn}
- Sub-module fetch_buf:
  - synchronous FWFT FIFO of fetch_entry_t, parameter DEPTH
  - push, pop and flush inputs; empty, full and count outputs
- Top module holds the PC registers, outstanding/drop counters and credit logic.

Test Plan:
- Reset then always-ready memory with 1-cycle response and out_ready = 1 -> out_pc sequence 0, 4, 8, 12… at one per cycle after fill; out_insn matches the memory image.
- out_ready = 0 with DEPTH=4, MAX_OUTST=2 -> exactly 4 entries accepted, imem_req_valid low after the 4th fire; release out_ready -> PCs 0, 4, 8, 12 in order, fetch resumes at 16.
- Redirect to 0x100 with 2 requests in flight -> the next 2 responses are dropped; the first out_pc after redirect = 0x100; no stale insn is ever presented.
- Redirect in the same cycle as a response and a request fire -> drop_cnt = 1 (the fired request only); the subsequent output is 0x100, 0x104.
- Back-to-back redirects to 0x200 then 0x300 -> only PCs from 0x300 appear; busy clears once the pipeline drains.
- fetch_pc = 0xFFFFFFFC sequential -> next request addr 0x0, and out_pc wraps identically.
- Async rst asserted mid-stream with a full queue -> out_valid = 0 and imem_req_valid = 0 immediately, without waiting for a clock edge; after release the first request addr = RESET_PC.
